// File: rtl/port_io_sequencer.sv
// Round-robin sequencer that shares one GPIO port bank between NUM_REQ requesters,
// running one strobe/ready bank transaction at a time with port-range and time-out errors.
module port_io_sequencer #(
  parameter int NUM_REQ   = 2,
  parameter int PORT_W    = 4,
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 10,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*PORT_W-1:0]   req_port,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic                        req_err,
  output logic [DATA_W-1:0]           rdata,
  output logic                        pio_cs,
  output logic                        pio_we,
  output logic [PORT_W-1:0]           pio_port,
  output logic [DATA_W-1:0]           pio_wdata,
  input  logic [DATA_W-1:0]           pio_rdata,
  input  logic                        pio_rdy,
  output logic                        busy
);

  localparam int          GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t              state_r;
  logic [GW-1:0]       last_grant_r;
  logic [GW-1:0]       grant_r;
  logic                we_r;
  logic [15:0]         timer_r;
  logic [GW-1:0]       pick_s;
  logic                pick_valid_s;
  logic                pick_bad_s;
  logic [PORT_W-1:0]   pick_port_s;
  logic [NUM_REQ-1:0]  grant_oh_s;

  // Round-robin pick: the lowest offset above last_grant wins, so scan from the far end down.
  always_comb begin : arb
    int idx;
    idx          = 0;
    pick_s       = last_grant_r;
    pick_valid_s = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx    = (int'(last_grant_r) + k) % NUM_REQ;
      pick_s = req[idx] ? GW'(idx) : pick_s;
    end
    pick_port_s = req_port[pick_s*PORT_W +: PORT_W];
    pick_bad_s  = (int'({1'b0, pick_port_s}) >= NUM_PORTS);
    grant_oh_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r;
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= GW'(NUM_REQ - 1);
      grant_r      <= '0;
      we_r         <= 1'b0;
      timer_r      <= 16'd0;
      req_ack      <= '0;
      req_err      <= 1'b0;
      rdata        <= '0;
      pio_cs       <= 1'b0;
      pio_we       <= 1'b0;
      pio_port     <= '0;
      pio_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_r <= pick_s;
            we_r    <= req_we[pick_s];
            busy    <= 1'b1;
            if (pick_bad_s) begin
              state_r <= ERR;
            end else begin
              state_r   <= ISSUE;
              pio_cs    <= 1'b1;
              pio_we    <= req_we[pick_s];
              pio_port  <= pick_port_s;
              pio_wdata <= req_wdata[pick_s*DATA_W +: DATA_W];
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          pio_cs  <= 1'b0;
          pio_we  <= 1'b0;
          timer_r <= 16'd0;
          state_r <= WAIT;
        end
        WAIT: begin
          // A ready on the expiry cycle still completes the transaction.
          if (pio_rdy) begin
            state_r <= DONE;
            req_ack <= grant_oh_s;
            req_err <= 1'b0;
            if (!we_r) begin
              rdata <= pio_rdata;
            end else begin
              rdata <= rdata;
            end
          end else if (timer_r == TIMEOUT_LAST) begin
            state_r <= ERR;
            req_ack <= grant_oh_s;
            req_err <= 1'b1;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        DONE: begin
          req_ack      <= '0;
          req_err      <= 1'b0;
          last_grant_r <= grant_r;
          busy         <= 1'b0;
          state_r      <= IDLE;
        end
        ERR: begin
          // Entered from IDLE on a bad port with no ack yet: spend one cycle raising it.
          if (req_ack == '0) begin
            req_ack <= grant_oh_s;
            req_err <= 1'b1;
          end else begin
            req_ack      <= '0;
            req_err      <= 1'b0;
            last_grant_r <= grant_r;
            busy         <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          req_ack <= '0;
          req_err <= 1'b0;
          pio_cs  <= 1'b0;
          pio_we  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_io_sequencer.sv
// Scoreboard bench for port_io_sequencer: directed transactions push expected bank strobes
// and acks (with cycle numbers) into queues; a negedge monitor pops and compares them.
module tb_port_io_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_we = 2'b00;
  logic [7:0]  req_port = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic [1:0]  req_ack;
  logic        req_err;
  logic [7:0]  rdata;
  logic        pio_cs;
  logic        pio_we;
  logic [3:0]  pio_port;
  logic [7:0]  pio_wdata;
  logic [7:0]  pio_rdata;
  logic        pio_rdy;
  logic        busy;

  port_io_sequencer #(
    .NUM_REQ(2), .PORT_W(4), .DATA_W(8), .NUM_PORTS(10), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_port(req_port),
    .req_wdata(req_wdata), .req_ack(req_ack), .req_err(req_err), .rdata(rdata),
    .pio_cs(pio_cs), .pio_we(pio_we), .pio_port(pio_port), .pio_wdata(pio_wdata),
    .pio_rdata(pio_rdata), .pio_rdy(pio_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [1:0] ack; logic err; logic [7:0] rdata; int cyc; } ack_exp_t;
  typedef struct { logic we; logic [3:0] port; logic [7:0] wdata; int cyc; } pio_exp_t;
  ack_exp_t ack_q[$];
  pio_exp_t pio_q[$];
  ack_exp_t ae;
  pio_exp_t pe;

  int         bank_delay = 0;
  logic [7:0] bank_data = 8'h00;
  logic [7:0] model_rdata = 8'h00;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack and every bank strobe must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ack != 2'b00) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", {30'd0, req_ack}, 32'd0);
        end else begin
          ae = ack_q.pop_front();
          check("ack_onehot", {30'd0, req_ack}, {30'd0, ae.ack});
          check("ack_err", {31'd0, req_err}, {31'd0, ae.err});
          check("ack_rdata", {24'd0, rdata}, {24'd0, ae.rdata});
          check("ack_cycle", cyc, ae.cyc);
        end
      end
      if (pio_cs) begin
        if (pio_q.size() == 0) begin
          check("unexpected_pio_cs", {31'd0, pio_cs}, 32'd0);
        end else begin
          pe = pio_q.pop_front();
          check("pio_we", {31'd0, pio_we}, {31'd0, pe.we});
          check("pio_port", {28'd0, pio_port}, {28'd0, pe.port});
          check("pio_wdata", {24'd0, pio_wdata}, {24'd0, pe.wdata});
          check("pio_cycle", cyc, pe.cyc);
        end
      end
    end
  end

  // Bank model: after a strobe, wait bank_delay WAIT cycles, then pulse ready for one cycle.
  initial begin
    pio_rdy = 1'b0;
    pio_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (pio_cs && bank_delay >= 0) begin
        @(posedge clk); #1;
        repeat (bank_delay) begin @(posedge clk); #1; end
        pio_rdy = 1'b1;
        pio_rdata = bank_data;
        @(posedge clk); #1;
        pio_rdy = 1'b0;
        pio_rdata = 8'h00;
      end
    end
  end

  // Expected timing with TIMEOUT=4: strobe at t0+1, ack at t0+3+delay if delay<=3,
  // else time-out ack at t0+6; bad port acks with error at t0+2.
  task automatic expect_txn(int r, logic we, logic [3:0] port, logic [7:0] wdata, int t0, int delay);
    logic [1:0] oh;
    oh = 2'b01 << r;
    if (port >= 4'd10) begin
      ack_q.push_back('{oh, 1'b1, model_rdata, t0 + 2});
    end else begin
      pio_q.push_back('{we, port, wdata, t0 + 1});
      if (delay >= 0 && delay <= 3) begin
        if (!we) model_rdata = bank_data;
        ack_q.push_back('{oh, 1'b0, model_rdata, t0 + 3 + delay});
      end else begin
        ack_q.push_back('{oh, 1'b1, model_rdata, t0 + 6});
      end
    end
  endtask

  task automatic drive_req(int r, logic we, logic [3:0] port, logic [7:0] wdata);
    req_we[r] = we;
    req_port[r*4 +: 4] = port;
    req_wdata[r*8 +: 8] = wdata;
    req[r] = 1'b1;
  endtask

  task automatic run_single(int r, logic we, logic [3:0] port, logic [7:0] wdata,
                            int delay, logic [7:0] data);
    int n;
    @(posedge clk); #1;
    bank_delay = delay;
    bank_data = data;
    expect_txn(r, we, port, wdata, cyc, delay);
    drive_req(r, we, port, wdata);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ack[r] && n < 60);
    check("ack_seen", {31'd0, req_ack[r]}, 32'd1);
    @(posedge clk); #1;
    req[r] = 1'b0;
    check("busy_after_ack", {31'd0, busy}, 32'd0);
  endtask

  // Both requesters write continuously; grants must alternate starting from requester 0.
  task automatic run_both(int n_txn);
    int t0;
    int got;
    int n;
    @(posedge clk); #1;
    bank_delay = 0;
    t0 = cyc;
    for (int k = 0; k < n_txn; k++) begin
      if (k % 2 == 0) expect_txn(0, 1'b1, 4'd2, 8'h11, t0 + 4*k, 0);
      else            expect_txn(1, 1'b1, 4'd7, 8'h22, t0 + 4*k, 0);
    end
    drive_req(0, 1'b1, 4'd2, 8'h11);
    drive_req(1, 1'b1, 4'd7, 8'h22);
    got = 0;
    n = 0;
    while (got < n_txn && n < 200) begin
      @(negedge clk);
      n++;
      if (req_ack != 2'b00) got++;
    end
    check("both_ack_count", got, n_txn);
    @(posedge clk); #1;
    req = 2'b00;
  endtask

  task automatic check_reset_outputs(string name);
    check(name, {6'd0, busy, req_ack, req_err, pio_cs, pio_we, rdata, pio_port, pio_wdata}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00;
    model_rdata = 8'h00;
    #1;
    check_reset_outputs("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    do_reset();
    // Write port 3, bank ready on first WAIT cycle.
    run_single(0, 1'b1, 4'd3, 8'hA5, 0, 8'h00);
    // Read port 9, ready after three idle WAIT cycles.
    run_single(1, 1'b0, 4'd9, 8'h00, 3, 8'h3C);
    // Out-of-range ports: no strobe, error ack, rdata unchanged.
    run_single(0, 1'b1, 4'd10, 8'h55, 0, 8'h00);
    run_single(0, 1'b0, 4'd15, 8'h00, 0, 8'h00);
    // Time-out, then ready exactly on the expiry cycle.
    run_single(0, 1'b0, 4'd4, 8'h00, -1, 8'hEE);
    run_single(1, 1'b0, 4'd6, 8'h00, 3, 8'h5A);
    // Write leaves rdata alone.
    run_single(0, 1'b1, 4'd1, 8'h77, 1, 8'hFF);
    // Fairness from reset.
    do_reset();
    run_both(4);
    // Reset in WAIT aborts silently; arbitration restarts at requester 0.
    @(posedge clk); #1;
    bank_delay = -1;
    t0 = cyc;
    pio_q.push_back('{1'b0, 4'd5, 8'h00, t0 + 1});
    drive_req(0, 1'b0, 4'd5, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("busy_in_wait", {31'd0, busy}, 32'd1);
    do_reset();
    check("no_pending_ack", ack_q.size(), 32'd0);
    run_both(2);
    repeat (4) @(posedge clk);
    check("ack_queue_drained", ack_q.size(), 32'd0);
    check("pio_queue_drained", pio_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
